// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter:
// owner encodings, default limits and counter sizing.
package dmem_arbiter_pkg;

    localparam int MAX_BURST_DEF    = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2
    } owner_e;

    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and dmem.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic [31:0] cpu_rd;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic        dma_gnt;
    logic [31:0] dma_rd;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  dma_req, dma_we, dma_addr, dma_wd,
        input  mem_rd,
        output cpu_gnt, cpu_stall, cpu_rd,
        output dma_gnt, dma_rd,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output dma_req, dma_we, dma_addr, dma_wd,
        output mem_rd,
        input  cpu_gnt, cpu_stall, cpu_rd,
        input  dma_gnt, dma_rd,
        input  mem_we, mem_a, mem_wd
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear and load-one controls.
// clr wins over load1, load1 wins over inc.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             load1,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load1) begin
            q <= ONE;
        end else if (inc && (q != QMAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between CPU load/store and DMA.
// Zero-latency grants; DMA bursts are capped, CPU starvation is bounded.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST    = MAX_BURST_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int BW = cnt_w(MAX_BURST);
    localparam int SW = cnt_w(STARVE_LIMIT);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    owner_e          owner;
    logic [BW-1:0]   burst_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            cpu_gnt;
    logic            dma_gnt;
    logic            force_dma;
    logic            yield_dma;
    logic            starve_hit;

    assign force_dma = bus.dma_req && (starve_cnt == SMAX);
    assign yield_dma = (burst_cnt == BMAX) && bus.cpu_req;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (owner)
            CPU_OWN: begin
                dma_gnt = force_dma || (!bus.cpu_req && bus.dma_req);
                cpu_gnt = !force_dma && bus.cpu_req;
            end
            DMA_OWN: begin
                dma_gnt = bus.dma_req && !yield_dma;
                cpu_gnt = !dma_gnt && bus.cpu_req;
            end
            default: begin
                cpu_gnt = bus.cpu_req;
                dma_gnt = !bus.cpu_req && bus.dma_req;
            end
        endcase
        // Reset kills any grant, so a pending store never reaches dmem.
        if (reset) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= IDLE;
        end else if (cpu_gnt) begin
            owner <= CPU_OWN;
        end else if (dma_gnt) begin
            owner <= DMA_OWN;
        end else begin
            owner <= IDLE;
        end
    end

    sat_counter #(
        .WIDTH (BW),
        .MAX   (MAX_BURST)
    ) u_burst (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_gnt && (owner == DMA_OWN)),
        .clr   (!dma_gnt),
        .load1 (dma_gnt && (owner != DMA_OWN)),
        .q     (burst_cnt)
    );

    assign starve_hit = cpu_gnt && bus.dma_req;

    sat_counter #(
        .WIDTH (SW),
        .MAX   (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_hit),
        .clr   (!starve_hit),
        .load1 (1'b0),
        .q     (starve_cnt)
    );

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;
    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;
    assign bus.mem_a     = dma_gnt ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_wd    = dma_gnt ? bus.dma_wd : bus.cpu_wd;
    assign bus.mem_we    = (cpu_gnt && bus.cpu_we) || (dma_gnt && bus.dma_we);
    assign bus.cpu_rd    = bus.mem_rd;
    assign bus.dma_rd    = bus.mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus
// burst, starvation and reset sequences against a small dmem.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];

    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("mutex", 32'(bus.cpu_gnt & bus.dma_gnt), 32'd0);
        check("we_match", 32'(bus.mem_we),
              32'((bus.cpu_gnt & bus.cpu_we) | (bus.dma_gnt & bus.dma_we)));
        check("stall_rule", 32'(bus.cpu_stall),
              32'(bus.cpu_req & ~bus.cpu_gnt));
    end

    task automatic drive(input logic cr, input logic cw,
                         input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        bus.cpu_req  = cr;
        bus.cpu_we   = cw;
        bus.cpu_addr = ca;
        bus.cpu_wd   = cd;
        bus.dma_req  = dr;
        bus.dma_we   = dw;
        bus.dma_addr = da;
        bus.dma_wd   = dd;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        ecg, edg, est;
        logic [1:0]  rdchk;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        tbl[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0,
                    1, 0, 0, 2'd0, 32'h0};
        tbl[1]  = '{1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0,
                    1, 0, 0, 2'd1, 32'hDEADBEEF};
        tbl[2]  = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                    0, 0, 0, 2'd0, 32'h0};
        for (int i = 3; i <= 6; i++)
            tbl[i] = '{1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0,
                       1, 0, 0, 2'd1, 32'hDEADBEEF};
        tbl[7]  = '{1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0,
                    0, 1, 1, 2'd2, 32'h0};
        tbl[8]  = '{0, 0, 32'h0, 32'h0, 1, 1, 32'h14, 32'h12345678,
                    0, 1, 0, 2'd0, 32'h0};
        tbl[9]  = '{1, 0, 32'h14, 32'h0, 0, 0, 32'h0, 32'h0,
                    1, 0, 0, 2'd1, 32'h12345678};
        tbl[10] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                    0, 0, 0, 2'd0, 32'h0};

        // Reset state: grants and writes blocked, stall follows cpu_req
        reset = 1'b1;
        drive(1, 1, 32'h10, 32'h1, 1, 1, 32'h10, 32'h2);
        #2;
        check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd1);
        next_cycle();
        reset = 1'b0;
        idle();
        check("rst_owner", 32'(dut.owner), 32'(IDLE));

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            @(negedge clk);
            check($sformatf("v%0d_cpu_gnt", i), 32'(bus.cpu_gnt),
                  32'(tbl[i].ecg));
            check($sformatf("v%0d_dma_gnt", i), 32'(bus.dma_gnt),
                  32'(tbl[i].edg));
            check($sformatf("v%0d_stall", i), 32'(bus.cpu_stall),
                  32'(tbl[i].est));
            if (tbl[i].rdchk == 2'd1)
                check($sformatf("v%0d_cpu_rd", i), bus.cpu_rd, tbl[i].erd);
            if (tbl[i].rdchk == 2'd2)
                check($sformatf("v%0d_dma_rd", i), bus.dma_rd, tbl[i].erd);
            next_cycle();
        end

        // DMA burst of 12, CPU asks from transfer 3 until granted
        for (int c = 1; c <= 13; c++) begin
            drive((c >= 3) && (c <= 9), 0, 32'h10, 32'h0,
                  1, 0, 32'h40, 32'h0);
            @(negedge clk);
            check($sformatf("b3_c%0d_dma_gnt", c), 32'(bus.dma_gnt),
                  32'((c <= 8) || (c >= 10)));
            check($sformatf("b3_c%0d_cpu_gnt", c), 32'(bus.cpu_gnt),
                  32'(c == 9));
            check($sformatf("b3_c%0d_stall", c), 32'(bus.cpu_stall),
                  32'((c >= 3) && (c <= 8)));
            next_cycle();
        end
        idle();
        next_cycle();

        // DMA burst of 12 with no CPU traffic: never yields
        for (int c = 1; c <= 12; c++) begin
            drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h44, 32'h0);
            @(negedge clk);
            check($sformatf("b4_c%0d_dma_gnt", c), 32'(bus.dma_gnt), 32'd1);
            check($sformatf("b4_c%0d_burst", c), 32'(dut.burst_cnt),
                  32'((c - 1 > 8) ? 8 : c - 1));
            next_cycle();
        end
        idle();
        check("b4_burst_sat", 32'(dut.burst_cnt), 32'd8);
        next_cycle();

        // Reset in the middle of a burst with a store to 0x20 pending
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h48, 32'h0);
            next_cycle();
        end
        drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'hCAFEF00D);
        #1;
        check("r5_pre_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        bus.cpu_req = 1'b1;
        #1;
        check("r5_mem_we", 32'(bus.mem_we), 32'd0);
        check("r5_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        check("r5_stall", 32'(bus.cpu_stall), 32'd1);
        next_cycle();
        check("r5_mem20", mem[8], 32'h0);
        reset = 1'b0;
        #1;
        check("r5_owner", 32'(dut.owner), 32'(IDLE));
        check("r5_first_cpu", 32'(bus.cpu_gnt), 32'd1);
        check("r5_first_dma", 32'(bus.dma_gnt), 32'd0);
        next_cycle();
        check("r5_mem20_after", mem[8], 32'h0);
        idle();
        next_cycle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
